var_delay_line: RTL and testbench

Runtime-programmable, valid-tagged delay line that replaces fixed-depth flop chains in the measurement datapath. Delay is selected in 1..MAX_DELAY enabled cycles through a load strobe, without rebuilding. Storage is a circular buffer with a write pointer and a derived read pointer, not a flop chain. The block adds clock-enable stall, flush, and a primed status, and sits between the sample front-end and the phase-difference stages to align paths of unequal latency.

---
 rtl/var_delay_line_if.sv | 25 ++
 rtl/var_delay_line.sv | 69 ++++++
 tb/tb_var_delay_line.sv | 99 +++++++++
 3 files changed

// File: rtl/var_delay_line_if.sv
// var_delay_line_if: sample, config and status bundle between the front-end and the delay line
interface var_delay_line_if #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DELAY = 16
);
  localparam int DLY_W = $clog2(MAX_DELAY + 1);
  logic en;
  logic [DATA_WIDTH-1:0] data_in;
  logic data_in_vld;
  logic [DLY_W-1:0] cfg_delay;
  logic cfg_load;
  logic flush;
  logic [DATA_WIDTH-1:0] data_out;
  logic data_out_vld;
  logic [DLY_W-1:0] delay_cur;
  logic primed;
  modport master (
    output en, data_in, data_in_vld, cfg_delay, cfg_load, flush,
    input data_out, data_out_vld, delay_cur, primed
  );
  modport slave (
    input en, data_in, data_in_vld, cfg_delay, cfg_load, flush,
    output data_out, data_out_vld, delay_cur, primed
  );
endinterface

// File: rtl/var_delay_line.sv
// var_delay_line: runtime-programmable valid-tagged delay line built on a circular buffer
module var_delay_line #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DELAY = 16,
  parameter int DEFAULT_DELAY = 10,
  localparam int DLY_W = $clog2(MAX_DELAY + 1)
) (
  input logic clk,
  input logic rst,
  var_delay_line_if.slave s_if
);
  localparam int WP_W = $clog2(MAX_DELAY);
  localparam int SW = DLY_W + 1;
  typedef enum logic {FILL, RUN} state_t;
  state_t r_state;
  logic [DATA_WIDTH-1:0] r_mem [MAX_DELAY];
  logic [MAX_DELAY-1:0] r_vld;
  logic [WP_W-1:0] r_wp, w_wp_nxt, w_rd;
  logic [SW-1:0] w_sum;
  logic [DLY_W-1:0] r_delay, r_cnt, w_clamp;
  logic [DATA_WIDTH-1:0] r_dout;
  logic r_dout_vld, r_primed, w_clr, w_wr, w_bypass;
  assign w_clr = s_if.flush | s_if.cfg_load;
  assign w_wr = s_if.en & ~w_clr & ~rst;
  assign w_bypass = r_delay == DLY_W'(1);
  assign w_clamp = s_if.cfg_delay == '0 ? DLY_W'(1)
                 : s_if.cfg_delay > DLY_W'(MAX_DELAY) ? DLY_W'(MAX_DELAY) : s_if.cfg_delay;
  assign w_wp_nxt = r_wp == WP_W'(MAX_DELAY - 1) ? '0 : r_wp + 1'b1;
  // entry written D-1 enabled edges ago sits D-1 slots behind wp, modulo MAX_DELAY
  assign w_sum = SW'(r_wp) + SW'(MAX_DELAY + 1) - SW'(r_delay);
  assign w_rd = w_sum >= SW'(MAX_DELAY) ? WP_W'(w_sum - SW'(MAX_DELAY)) : WP_W'(w_sum);
  assign s_if.data_out = r_dout;
  assign s_if.data_out_vld = r_dout_vld;
  assign s_if.delay_cur = r_delay;
  assign s_if.primed = r_primed;
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= s_if.data_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_vld <= '0;
      r_dout <= '0;
      r_dout_vld <= 1'b0;
      r_delay <= DLY_W'(DEFAULT_DELAY);
      r_cnt <= DLY_W'(DEFAULT_DELAY);
      r_state <= FILL;
      r_primed <= 1'b0;
    end else if (w_clr) begin
      r_vld <= '0;
      r_dout_vld <= 1'b0;
      r_delay <= s_if.cfg_load ? w_clamp : r_delay;
      r_cnt <= s_if.cfg_load ? w_clamp : r_delay;
      r_state <= FILL;
      r_primed <= 1'b0;
    end else if (s_if.en) begin
      r_vld[r_wp] <= s_if.data_in_vld;
      r_wp <= w_wp_nxt;
      r_dout <= w_bypass ? s_if.data_in : r_mem[w_rd];
      r_dout_vld <= w_bypass ? s_if.data_in_vld : r_vld[w_rd];
      if (r_state == FILL) begin
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == DLY_W'(1)) begin
          r_state <= RUN;
          r_primed <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_var_delay_line.sv
// tb_var_delay_line: random and directed stimulus against a history-queue model of an ideal D-stage line
module tb_var_delay_line;
  localparam int DW = 32;
  localparam int MD = 16;
  localparam int DD = 10;
  localparam int DLW = $clog2(MD + 1);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW:0] hist [$];
  int mdly = DD;
  int n_chk = 0;
  int n_bad = 0;
  var_delay_line_if #(.DATA_WIDTH(DW), .MAX_DELAY(MD)) bus ();
  var_delay_line #(.DATA_WIDTH(DW), .MAX_DELAY(MD), .DEFAULT_DELAY(DD)) dut (
    .clk(clk),
    .rst(rst),
    .s_if(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // model: samples captured since the last clear; output is the one captured D-1 captures before the newest
  task automatic step(input logic r, input logic e, input logic v, input logic [DW-1:0] d,
                      input logic f, input logic l, input logic [DLW-1:0] c);
    logic [DW:0] s;
    rst = r;
    bus.en = e;
    bus.data_in_vld = v;
    bus.data_in = d;
    bus.flush = f;
    bus.cfg_load = l;
    bus.cfg_delay = c;
    @(posedge clk);
    if (r) begin
      hist.delete();
      mdly = DD;
    end else if (f || l) begin
      hist.delete();
      if (l) mdly = (c == 0) ? 1 : (int'(c) > MD ? MD : int'(c));
    end else if (e) begin
      hist.push_back({v, d});
      if (hist.size() > MD) void'(hist.pop_front());
    end
    #1;
    chk("delay_cur", 64'(bus.delay_cur), 64'(mdly));
    chk("primed", 64'(bus.primed), 64'(hist.size() >= mdly));
    if (hist.size() >= mdly) begin
      s = hist[hist.size() - mdly];
      chk("out_vld", 64'(bus.data_out_vld), 64'(s[DW]));
      if (s[DW]) chk("out_data", 64'(bus.data_out), 64'(s[DW-1:0]));
    end else begin
      chk("out_vld_empty", 64'(bus.data_out_vld), 64'd0);
    end
    if (r) chk("rst_dout", 64'(bus.data_out), 64'd0);
  endtask
  initial begin
    step(1, 0, 0, '0, 0, 0, '0);
    step(1, 1, 1, 32'hFFFF_FFFF, 1, 1, DLW'(3));
    for (int i = 1; i <= 12; i++) begin
      step(0, 1, 1, DW'(i), 0, 0, '0);
      if (i == 10) chk("first_out", 64'(bus.data_out), 64'd1);
    end
    step(0, 1, 1, $urandom, 0, 1, DLW'(1));
    step(0, 1, 1, 32'hA5, 0, 0, '0);
    chk("bypass_a5", 64'(bus.data_out), 64'hA5);
    for (int i = 0; i < 8; i++) step(0, 1, 1, $urandom, 0, 0, '0);
    step(0, 1, 1, $urandom, 0, 1, DLW'(0));
    chk("clamp_lo", 64'(bus.delay_cur), 64'd1);
    step(0, 1, 1, $urandom, 0, 1, DLW'(31));
    chk("clamp_hi", 64'(bus.delay_cur), 64'd16);
    step(0, 1, 1, 32'hBEEF_0016, 0, 0, '0);
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 0, $urandom, 0, 0, '0);
      if (i == 15) chk("d16_data", 64'(bus.data_out), 64'hBEEF_0016);
    end
    step(0, 1, 1, $urandom, 0, 1, DLW'(4));
    for (int i = 0; i < 24; i++) step(0, (i % 2) == 0, 1, $urandom, 0, 0, '0);
    for (int i = 0; i < 6; i++) step(0, 1, 1, $urandom, 0, 0, '0);
    step(0, 1, 1, $urandom, 1, 0, '0);
    chk("flush_vld", 64'(bus.data_out_vld), 64'd0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, $urandom, 0, 0, '0);
    step(0, 1, 1, $urandom, 1, 1, DLW'(6));
    chk("flush_load_dly", 64'(bus.delay_cur), 64'd6);
    for (int i = 0; i < 8; i++) step(0, 1, 1, $urandom, 0, 0, '0);
    step(1, 1, 1, $urandom, 0, 0, '0);
    chk("rst_dly", 64'(bus.delay_cur), 64'd10);
    for (int i = 0; i < 14; i++) step(0, 1, 1, $urandom, 0, 0, '0);
    for (int i = 0; i < 800; i++)
      step($urandom_range(99) == 0, $urandom_range(9) < 7, $urandom_range(3) != 0, $urandom,
           $urandom_range(99) < 3, $urandom_range(99) < 3, DLW'($urandom_range(31)));
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
